// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Instruction-memory fetch bus between the fetch stage and instruction memory.
//   IMemAddr  : word-aligned byte address of the requested instruction
//   IMemReq   : fetch request, held until IMemReady is seen
//   IMemReady : memory presents IMemData for IMemAddr this cycle
//   IMemData  : 32-bit instruction word
// Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;
   logic [31:0] IMemAddr;
   logic        IMemReq;
   logic        IMemReady;
   logic [31:0] IMemData;

   modport master (
      output IMemAddr,
      output IMemReq,
      input  IMemReady,
      input  IMemData
   );

   modport slave (
      input  IMemAddr,
      input  IMemReq,
      output IMemReady,
      output IMemData
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// MIPS-32 instruction fetch stage. Holds the PC, fetches one instruction word
// per request over the imem handshake, latches it into the instruction
// register and computes the next PC from Jump / Branch / Zero when the
// downstream stage signals Advance.
// Ports:
//   Clk, Reset_n      : clock, asynchronous active-low reset
//   imem (master)     : IMemAddr/IMemReq out, IMemReady/IMemData in
//   Advance           : current instruction consumed, PC may move on
//   Branch, Zero, Jump: next-PC selection, sampled in the Advance cycle
//   Instruction       : instruction register
//   OpCode            : Instruction[31:26]
//   PC, PCPlus4       : address of Instruction and PC + 4 (mod 2^32)
//   InstrValid        : Instruction holds a fetched, not-yet-retired word
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                            Clk,
   input  logic                            Reset_n,
   instruction_fetch_unit_if.master        imem,
   input  logic                            Advance,
   input  logic                            Branch,
   input  logic                            Zero,
   input  logic                            Jump,
   output logic [31:0]                     Instruction,
   output logic [5:0]                      OpCode,
   output logic [31:0]                     PC,
   output logic [31:0]                     PCPlus4,
   output logic                            InstrValid
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;

   logic [31:0] pc_plus4;
   logic [31:0] next_pc;

   // PC-relative branch target: sign-extended word offset added to PC+4;
   // the carry out of bit 31 is dropped so the address wraps.
   function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                 input logic [15:0] imm);
      logic signed [31:0] offset;
      offset = {{14{imm[15]}}, imm, 2'b00};
      return pc4 + $unsigned(offset);
   endfunction

   assign pc_plus4 = pc_q + 32'd4;

   // Jump has priority over a taken branch.
   always_comb begin
      next_pc = pc_plus4;
      if (Jump) begin
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (Branch && Zero) begin
         next_pc = branch_target(pc_plus4, instr_q[15:0]);
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      case (state_q)
         FETCH: begin
            if (imem.IMemReady) begin
               instr_d = imem.IMemData;
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (Advance) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC_ALIGNED;
         instr_q <= 32'h0000_0000;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   // Request is decoded from state only; gating with Reset_n makes it drop
   // the moment reset is asserted, even between clock edges.
   assign imem.IMemReq  = (state_q == FETCH) && Reset_n;
   assign imem.IMemAddr = pc_q;

   assign Instruction = instr_q;
   assign OpCode      = instr_q[31:26];
   assign PC          = pc_q;
   assign PCPlus4     = pc_plus4;
   assign InstrValid  = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_a_n = 1'b0;
   logic        rst_b_n = 1'b0;
   logic        sel = 1'b0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_data = 32'hDEAD_BEEF;
   logic        advance = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic        jump = 1'b0;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } iss_t;

   logic [31:0] exp_addr_q[$];
   iss_t        exp_iss_q[$];

   always #5 clk = ~clk;

   instruction_fetch_unit_if if_a ();
   instruction_fetch_unit_if if_b ();

   assign if_a.IMemReady = imem_ready;
   assign if_a.IMemData  = imem_data;
   assign if_b.IMemReady = imem_ready;
   assign if_b.IMemData  = imem_data;

   logic [31:0] instr_a, pc_a, pc4_a, instr_b, pc_b, pc4_b;
   logic [5:0]  op_a, op_b;
   logic        valid_a, valid_b;

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
      .Clk(clk), .Reset_n(rst_a_n), .imem(if_a),
      .Advance(advance), .Branch(branch), .Zero(zero), .Jump(jump),
      .Instruction(instr_a), .OpCode(op_a), .PC(pc_a), .PCPlus4(pc4_a),
      .InstrValid(valid_a)
   );

   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
      .Clk(clk), .Reset_n(rst_b_n), .imem(if_b),
      .Advance(advance), .Branch(branch), .Zero(zero), .Jump(jump),
      .Instruction(instr_b), .OpCode(op_b), .PC(pc_b), .PCPlus4(pc4_b),
      .InstrValid(valid_b)
   );

   // Outputs of whichever DUT is under test
   logic        mon_req, mon_valid;
   logic [31:0] mon_addr, mon_instr, mon_pc, mon_pc4;
   logic [5:0]  mon_op;

   always_comb begin
      mon_req   = sel ? if_b.IMemReq  : if_a.IMemReq;
      mon_addr  = sel ? if_b.IMemAddr : if_a.IMemAddr;
      mon_valid = sel ? valid_b : valid_a;
      mon_instr = sel ? instr_b : instr_a;
      mon_pc    = sel ? pc_b    : pc_a;
      mon_pc4   = sel ? pc4_b   : pc4_a;
      mon_op    = sel ? op_b    : op_a;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge and compares against the scoreboard.
   always @(negedge clk) begin
      if (mon_req) begin
         check("valid_low_in_fetch", {31'd0, mon_valid}, 32'd0);
         if (exp_addr_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL fetch_unexpected: got addr %h, expected no request", mon_addr);
         end else begin
            check("imem_addr", mon_addr, exp_addr_q[0]);
            if (imem_ready) void'(exp_addr_q.pop_front());
         end
      end
      if (mon_valid) begin
         if (exp_iss_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL issue_unexpected: got instr %h, expected none", mon_instr);
         end else begin
            check("instruction", mon_instr, exp_iss_q[0].instr);
            check("pc", mon_pc, exp_iss_q[0].pc);
            check("pc_plus4", mon_pc4, exp_iss_q[0].pc + 32'd4);
            check("opcode", {26'd0, mon_op}, {26'd0, exp_iss_q[0].instr[31:26]});
            if (advance) void'(exp_iss_q.pop_front());
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Fetch at addr: 'waits' cycles with IMemReady low (Advance/Jump driven
   // high meanwhile, which the DUT must ignore in FETCH), then one ready cycle.
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int waits);
      iss_t e;
      e.instr = data;
      e.pc    = addr;
      exp_addr_q.push_back(addr);
      exp_iss_q.push_back(e);
      imem_ready = 1'b0;
      advance    = (waits > 0);
      jump       = (waits > 0);
      repeat (waits) cyc();
      advance    = 1'b0;
      jump       = 1'b0;
      imem_ready = 1'b1;
      imem_data  = data;
      cyc();
      imem_ready = 1'b1;
      imem_data  = 32'hDEAD_BEEF;
      imem_ready = 1'b0;
   endtask

   task automatic do_issue(input int stalls, input logic br, input logic zr, input logic jp);
      branch  = br;
      zero    = zr;
      jump    = jp;
      advance = 1'b0;
      repeat (stalls) cyc();
      advance = 1'b1;
      cyc();
      advance = 1'b0;
      branch  = 1'b0;
      zero    = 1'b0;
      jump    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) cyc();
      check("rst_req", {31'd0, mon_req}, 32'd0);
      check("rst_valid", {31'd0, mon_valid}, 32'd0);
      check("rst_instr", mon_instr, 32'h0);
      check("rst_pc", mon_pc, 32'h0);

      // ---- DUT A, RESET_PC = 0 ----
      rst_a_n = 1'b1;
      do_fetch(32'h0000_0000, 32'h8C08_0004, 0);   // lw, opcode 100011
      do_issue(0, 1'b0, 1'b0, 1'b0);              // -> 0x4
      do_fetch(32'h0000_0004, 32'h0000_0020, 3);   // 3 wait states
      do_issue(2, 1'b0, 1'b0, 1'b0);              // stall 2, -> 0x8
      do_fetch(32'h0000_0008, 32'h0000_0000, 0);
      do_issue(0, 1'b0, 1'b1, 1'b0);              // Zero alone: -> 0xC
      do_fetch(32'h0000_000C, 32'h0000_0000, 0);
      do_issue(0, 1'b0, 1'b0, 1'b0);              // -> 0x10
      do_fetch(32'h0000_0010, 32'h1000_FFFF, 0);
      do_issue(0, 1'b1, 1'b1, 1'b0);              // taken, offset -4: -> 0x10
      do_fetch(32'h0000_0010, 32'h1000_FFFF, 1);
      do_issue(1, 1'b1, 1'b0, 1'b0);              // not taken: -> 0x14
      do_fetch(32'h0000_0014, 32'h1000_0002, 0);
      do_issue(0, 1'b1, 1'b1, 1'b0);              // taken, +8: 0x18+8 -> 0x20
      do_fetch(32'h0000_0020, 32'h0800_0040, 0);
      do_issue(0, 1'b1, 1'b1, 1'b1);              // Jump wins: -> 0x100
      do_fetch(32'h0000_0100, 32'h2408_0007, 0);
      cyc();
      check("a_addr_drained", exp_addr_q.size(), 32'd0);

      // ---- DUT B, RESET_PC = 0xFFFF_FFFC ----
      rst_a_n = 1'b0;
      sel     = 1'b1;
      exp_addr_q.delete();
      exp_iss_q.delete();
      cyc();
      rst_b_n = 1'b1;
      do_fetch(32'hFFFF_FFFC, 32'h2402_0001, 0);
      do_issue(0, 1'b0, 1'b0, 1'b0);              // wraps -> 0x0
      exp_addr_q.push_back(32'h0000_0000);
      imem_ready = 1'b0;
      cyc();
      cyc();
      #2;
      rst_b_n = 1'b0;                             // mid-FETCH, between edges
      #1;
      check("async_rst_req", {31'd0, mon_req}, 32'd0);
      check("async_rst_valid", {31'd0, mon_valid}, 32'd0);
      check("async_rst_pc", mon_pc, 32'hFFFF_FFFC);
      check("b_wrap_fetch_seen", exp_addr_q.size(), 32'd1);
      exp_addr_q.delete();
      exp_iss_q.delete();
      cyc();
      rst_b_n = 1'b1;
      do_fetch(32'hFFFF_FFFC, 32'h3C01_1234, 0);  // restart at RESET_PC
      do_issue(1, 1'b0, 1'b0, 1'b0);              // -> 0x0
      do_fetch(32'h0000_0000, 32'h0000_0000, 1);
      cyc();
      check("b_addr_drained", exp_addr_q.size(), 32'd0);
      check("b_issue_pending", exp_iss_q.size(), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the MIPS-32 datapath. It holds the program counter, fetches one 32-bit instruction word per request from instruction memory over a request/ready handshake, and latches it into the instruction register. The OpCode field drives the control unit directly. The block computes the next PC from the control unit's Branch and Jump outputs and the ALU Zero flag.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] ignored (forced 0)
- Clk  in  1  system clock, all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- IMemAddr  out  32  instruction memory word address (byte address, bits [1:0] always 0)
- IMemReq  out  1  fetch request to instruction memory
- IMemReady  in  1  memory has IMemData valid for IMemAddr this cycle
- IMemData  in  32  instruction word from memory
- Advance  in  1  downstream has consumed current instruction; PC may move on
- Branch  in  1  branch instruction decoded (from control unit)
- Zero  in  1  ALU zero flag for current instruction
- Jump  in  1  jump instruction decoded (from control unit)
- Instruction  out  32  instruction register contents
- OpCode  out  6  Instruction[31:26], to control unit
- PC  out  32  address of the instruction in Instruction
- PCPlus4  out  32  PC + 4, modulo 2^32
- InstrValid  out  1  Instruction holds a fetched, not-yet-retired word

## Operation
- Two-state FSM: FETCH, ISSUE.
- Reset (Reset_n low, asynchronous): state=FETCH, PC={RESET_PC[31:2],2'b00}, Instruction=0, InstrValid=0. IMemReq is held 0 while Reset_n is low.
- FETCH: IMemReq=1, IMemAddr=PC, InstrValid=0. On IMemReady=1: Instruction<=IMemData, go to ISSUE. Otherwise stay in FETCH with IMemAddr held stable.
- ISSUE: IMemReq=0, InstrValid=1, Instruction held. On Advance=1: PC<=NextPC, go to FETCH. Otherwise hold.
- NextPC priority:
  - Jump=1: {PCPlus4[31:28], Instruction[25:0], 2'b00}.
  - Else Branch=1 and Zero=1: PCPlus4 + ({{14{Instruction[15]}}, Instruction[15:0], 2'b00}), 32-bit, carry discarded.
  - Else PCPlus4.
- All PC arithmetic wraps modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000.
- Branch, Zero, Jump and Advance are ignored in FETCH. IMemReady and IMemData are ignored in ISSUE.
- OpCode is always Instruction[31:26], including when InstrValid=0. Consumers must qualify with InstrValid.

## Timing
- IMemReq and IMemAddr are registered-state functions with no combinational path from IMemReady.
- Minimum 2 cycles per instruction:
  - FETCH with IMemReady high in the first cycle.
  - ISSUE with Advance high in the first cycle.
- Each memory wait cycle adds 1 cycle. Each cycle Advance is low in ISSUE adds 1 cycle.
- Instruction and InstrValid update on the edge where IMemReady=1 is sampled in FETCH. They are visible in the following cycle.
- The new PC is visible in the cycle after Advance is sampled; IMemReq rises in that same cycle.
- NextPC is evaluated from Branch, Zero and Jump in the Advance cycle. Those inputs must be valid in that cycle.
- Reset asserted mid-FETCH or mid-ISSUE:
  - Immediately: IMemReq=0 and InstrValid=0.
  - Any in-flight response is discarded.
  - After Reset_n deasserts, fetch restarts at RESET_PC.

## Test plan
- Reset/first fetch:
  - Stimulus: RESET_PC=0; release reset; IMemReady=1 with IMemData=0x8C08_0004.
  - Required: IMemAddr=0 with IMemReq=1 in the first cycle. Next cycle: InstrValid=1, OpCode=6'b100011, PC=0, PCPlus4=4.
- Memory wait states:
  - Stimulus: hold IMemReady=0 for 3 cycles at PC=4.
  - Required: IMemAddr stays 4 and InstrValid stays 0. Instruction loads on the 4th cycle.
- Sequential and stall:
  - Stimulus: in ISSUE, Advance=0 for 2 cycles, then 1, with Branch=Jump=0.
  - Required: Instruction and PC held during the stall. Next PC is 8.
- Branch:
  - Stimulus: PC=0x10, Instruction=0x1000_FFFF.
  - Required with Branch=1, Zero=1 and Advance: next PC=0x10.
  - Required with Zero=0: next PC=0x14.
- Jump:
  - Stimulus: PC=0x20, Instruction=0x0800_0040, Jump=1 and Branch=1 with Zero=1.
  - Required: next PC=0x0000_0100 (Jump wins).
- Wrap and async reset:
  - Stimulus: RESET_PC=0xFFFF_FFFC; sequential advance.
  - Required: PC becomes 0x0000_0000.
  - Stimulus: then pulse Reset_n low mid-FETCH, between clock edges.
  - Required: IMemReq drops immediately. Fetch restarts at 0xFFFF_FFFC after release.
